ysyx_25040111_lsu_axi: RTL

Parametrised load/store unit that turns one core memory request into a single-beat AXI4 master transaction. It sits between the execute stage and the SoC crossbar. It generalises the fixed 32-bit LSU in three ways: configurable address and data width, a valid/ready request and response interface, and explicit misalignment and bus-error reporting. AW and W are issued independently, so each channel may handshake in either order.

---
 rtl/ysyx_25040111_lsu_axi.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040111_lsu_axi.sv
// rtl/ysyx_25040111_lsu_axi.sv - single-beat AXI4 master load/store unit
module ysyx_25040111_lsu_axi #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int AXI_ID      = 0,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic                req_sign,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [3:0]          bid,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic [3:0]          rid
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;
  state_t state;

  logic [OFF_W-1:0]  req_off, off_q, align_mask;
  logic [NB-1:0]     strb_base;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              illegal, misaligned, local_err;
  logic              r_err, b_err;
  logic [DATA_W-1:0] shifted, keep, load_ext;
  logic              sbit;
  logic              unused_rlast;

  assign unused_rlast = rlast;

  assign req_ready = (state == S_IDLE);
  assign rready    = (state == S_R);
  assign bready    = (state == S_B);
  assign awid      = 4'(AXI_ID);
  assign arid      = 4'(AXI_ID);
  assign awlen     = 8'd0;
  assign arlen     = 8'd0;
  assign awburst   = 2'b01;
  assign arburst   = 2'b01;
  assign wlast     = 1'b1;

  assign r_err = (rresp != 2'b00) || (rid != 4'(AXI_ID));
  assign b_err = (bresp != 2'b00) || (bid != 4'(AXI_ID));

  always_comb begin
    req_off    = req_addr[OFF_W-1:0];
    align_mask = '0;
    strb_base  = NB'(1);
    case (req_size)
      2'd0: begin align_mask = '0;         strb_base = NB'(1);     end
      2'd1: begin align_mask = OFF_W'(1);  strb_base = NB'(3);     end
      2'd2: begin align_mask = OFF_W'(3);  strb_base = NB'(4'hF);  end
      default: begin align_mask = '1;      strb_base = '1;         end
    endcase
    illegal    = (DATA_W == 32) && (req_size == 2'd3);
    misaligned = |(req_off & align_mask);
    local_err  = illegal || ((CHECK_ALIGN != 0) && misaligned);
  end

  // Extract the addressed field from the read beat and extend it to full width.
  always_comb begin
    shifted = rdata >> {off_q, 3'b000};
    keep    = '1;
    sbit    = shifted[DATA_W-1];
    case (size_q)
      2'd0: begin keep = DATA_W'(8'hFF);        sbit = shifted[7];  end
      2'd1: begin keep = DATA_W'(16'hFFFF);     sbit = shifted[15]; end
      2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: begin keep = '1;                 sbit = shifted[DATA_W-1]; end
    endcase
    load_ext = (shifted & keep) | ({DATA_W{sign_q & sbit}} & ~keep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      arvalid    <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 2'd0;
      araddr     <= '0;
      awaddr     <= '0;
      arsize     <= 3'd0;
      awsize     <= 3'd0;
      wdata      <= '0;
      wstrb      <= '0;
      off_q      <= '0;
      size_q     <= 2'd0;
      sign_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            off_q  <= req_off;
            size_q <= req_size;
            sign_q <= req_sign;
            if (local_err) begin
              resp_rdata <= '0;
              resp_err   <= 2'd1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else if (req_wen) begin
              awaddr  <= req_addr;
              awsize  <= {1'b0, req_size};
              wdata   <= req_wdata << {req_off, 3'b000};
              wstrb   <= strb_base << req_off;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR;
            end else begin
              araddr  <= req_addr;
              arsize  <= {1'b0, req_size};
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            resp_rdata <= load_ext;
            resp_err   <= r_err ? 2'd2 : 2'd0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_WR: begin
          // AW and W complete independently; move on once neither is still pending.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) state <= S_B;
        end
        S_B: begin
          if (bvalid) begin
            resp_rdata <= '0;
            resp_err   <= b_err ? 2'd2 : 2'd0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
